angle_sipo_packer: RTL and testbench
====================================

// Module: angle_sipo_packer
// PURPOSE
//  Downstream stage of the multiplexed arctan2 path. Collects the serial angle stream
//  (one angle per valid cycle) and repacks PARALLEL consecutive angles into one wide word.
//  The wide word matches the lane order of the PARALLEL-wide x/y input that fed the PISO.
//  Optional sync input realigns frames; partial frames are discarded and counted.
// PARAMETERS
//  DIN_WIDTH   16  width of one angle sample
//  PARALLEL    4   angles per output word (>=2)
//  CNT_WIDTH   16  width of frame_count and drop_count
// PORTS
//  clk          in   1                    clock; all logic on rising edge
//  rst_n        in   1                    async reset, active low
//  ce           in   1                    clock enable; low = hold state
//  din          in   DIN_WIDTH            angle sample from arctan2 dout
//  din_valid    in   1                    din qualifier; no backpressure, every valid consumed
//  sync         in   1                    frame start; realigns lane counter to lane 0
//  dout         out  PARALLEL*DIN_WIDTH   packed word; lane k at [k*DIN_WIDTH +: DIN_WIDTH]
//  dout_valid   out  1                    one-cycle pulse per completed word
//  frame_drop   out  1                    one-cycle pulse when a partial frame is discarded
//  busy         out  1                    high while a partial frame is held (lane_cnt != 0)
//  frame_count  out  CNT_WIDTH            completed words, wraps modulo 2**CNT_WIDTH
//  drop_count   out  CNT_WIDTH            discarded partial frames, saturates at all-ones
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset (rst_n=0, async): dout=0, dout_valid=0, frame_drop=0, busy=0, lane_cnt=0,
//    frame_count=0, drop_count=0, and the lane buffer is cleared. Deassertion mid-frame
//    discards the partial frame without counting a drop.
//  - State: lane_cnt in 0..PARALLEL-1 and a lane buffer of PARALLEL-1 samples.
//    The last lane is never buffered: it is written directly into dout.
//  - ce=0: all registers hold, except dout_valid and frame_drop, which clear to 0.
//  - Accept (ce & din_valid & !sync): lane[lane_cnt] <= din.
//    - If lane_cnt==PARALLEL-1: dout <= {din, lane[PARALLEL-2..0]}, dout_valid <= 1,
//      frame_count++, lane_cnt <= 0.
//    - Otherwise: lane_cnt++.
//  - Latency: dout_valid rises on the edge after the cycle carrying the last lane (1 cycle).
//  - dout holds its last word until the next completion; dout_valid is never held >1 cycle.
//  - Back-to-back operation: with valid every cycle, dout_valid pulses every PARALLEL cycles.
//  - sync & din_valid (ce=1): din becomes lane 0 of a new frame and lane_cnt <= 1.
//    - If lane_cnt was !=0: frame_drop <= 1, drop_count++ (saturating), buffer contents discarded.
//  - sync & !din_valid (ce=1): lane_cnt <= 0; a partial frame is dropped and counted as above.
//  - sync with lane_cnt==0 is a no-op realignment: no drop.
//  - sync arriving on the cycle that would complete a frame wins: no dout_valid, a drop is
//    counted, and din starts the new frame.
//  - PARALLEL==1 is illegal (compile-time error via generate check).
//  - busy = (lane_cnt != 0), registered.
//  - Arithmetic: samples are passed bit-exact (no sign handling); counters are unsigned.
// TESTING
//  1 Reset: drive rst_n=0 mid-stream -> all outputs 0 immediately; next 4 valids form
//    a word starting at lane 0.
//  2 PARALLEL=4, DIN_WIDTH=16: valids 0x0001,0x0002,0x0003,0x0004 on consecutive cycles
//    -> dout=0x0004_0003_0002_0001, dout_valid one cycle after 4th sample, frame_count=1.
//  3 Continuous valids for 12 cycles -> exactly 3 dout_valid pulses, 4 cycles apart,
//    frame_count=3.
//  4 Gapped valids (valid 1 of every 3 cycles) plus ce=0 for 5 cycles inside a frame
//    -> same packed word as test 2; no pulse during ce=0.
//  5 Two samples, then sync with valid carrying 0x00AA -> frame_drop pulse, drop_count=1;
//    the next 3 samples complete a word with lane0=0x00AA.
//  6 CNT_WIDTH=2: force 5 partial-frame drops -> drop_count saturates at 3;
//    5 complete frames -> frame_count wraps to 1.

Source files
------------

// File: rtl/angle_sipo_packer.sv
// Serial-to-parallel packer for the multiplexed arctan2 angle stream.
// Gathers PARALLEL consecutive angles into one wide word, with sync realignment and drop counting.
module angle_sipo_packer #(
    parameter int unsigned DIN_WIDTH = 16,
    parameter int unsigned PARALLEL  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic [DIN_WIDTH-1:0]          din,
    input  logic                          din_valid,
    input  logic                          sync,
    output logic [PARALLEL*DIN_WIDTH-1:0] dout,
    output logic                          dout_valid,
    output logic                          frame_drop,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          frame_count,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam int unsigned DOUT_WIDTH = PARALLEL * DIN_WIDTH;
    localparam int unsigned LANE_CW    = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
    localparam int unsigned BUF_N      = (PARALLEL > 1) ? PARALLEL - 1 : 1;
    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(PARALLEL - 1);

    if (PARALLEL < 2) begin : g_parallel_check
        $error("angle_sipo_packer: PARALLEL must be at least 2");
    end

    // Lane k of the buffer sits at the low end so {din, lane_q} yields the output lane order
    logic [BUF_N-1:0][DIN_WIDTH-1:0] lane_q, lane_d;
    logic [LANE_CW-1:0]              lane_cnt_q, lane_cnt_d;
    logic [DOUT_WIDTH-1:0]           dout_q, dout_d;
    logic                            dout_valid_q, dout_valid_d;
    logic                            frame_drop_q, frame_drop_d;
    logic                            busy_q, busy_d;
    logic [CNT_WIDTH-1:0]            frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0]            drop_count_q, drop_count_d;

    // Next-state: sync takes priority over accept, including on a frame-completing cycle
    always_comb begin
        lane_d        = lane_q;
        lane_cnt_d    = lane_cnt_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        frame_drop_d  = 1'b0;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        if (ce) begin
            if (sync) begin
                if (lane_cnt_q != '0) begin
                    frame_drop_d = 1'b1;
                    if (drop_count_q != '1) begin
                        drop_count_d = drop_count_q + CNT_WIDTH'(1);
                    end
                end
                if (din_valid) begin
                    lane_d[0]  = din;
                    lane_cnt_d = LANE_CW'(1);
                end else begin
                    lane_cnt_d = '0;
                end
            end else if (din_valid) begin
                if (lane_cnt_q == LAST_LANE) begin
                    dout_d        = {din, lane_q};
                    dout_valid_d  = 1'b1;
                    frame_count_d = frame_count_q + CNT_WIDTH'(1);
                    lane_cnt_d    = '0;
                end else begin
                    for (int unsigned k = 0; k < BUF_N; k++) begin
                        if (lane_cnt_q == LANE_CW'(k)) begin
                            lane_d[k] = din;
                        end
                    end
                    lane_cnt_d = lane_cnt_q + LANE_CW'(1);
                end
            end
        end

        busy_d = (lane_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q        <= '0;
            lane_cnt_q    <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            frame_drop_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            lane_q        <= lane_d;
            lane_cnt_q    <= lane_cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_drop_q  <= frame_drop_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_drop  = frame_drop_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_angle_sipo_packer.sv
// Directed bench for angle_sipo_packer: vector table plus hand sequences for reset,
// streaming and counter width corners (second instance with 2-bit counters).
module tb_angle_sipo_packer;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [15:0] din;
    logic        din_valid;
    logic        sync;

    logic [63:0] dout, dout_c2;
    logic        dout_valid, dout_valid_c2;
    logic        frame_drop, frame_drop_c2;
    logic        busy, busy_c2;
    logic [15:0] frame_count, drop_count;
    logic [1:0]  frame_count_c2, drop_count_c2;

    int checks   = 0;
    int failures = 0;

    angle_sipo_packer #(.DIN_WIDTH(16), .PARALLEL(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_valid(din_valid), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .frame_drop(frame_drop), .busy(busy),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    angle_sipo_packer #(.DIN_WIDTH(16), .PARALLEL(4), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_valid(din_valid), .sync(sync),
        .dout(dout_c2), .dout_valid(dout_valid_c2), .frame_drop(frame_drop_c2), .busy(busy_c2),
        .frame_count(frame_count_c2), .drop_count(drop_count_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic        valid;
        logic        sync;
        logic [15:0] din;
        logic        exp_dv;
        logic        exp_fd;
        logic        exp_busy;
        logic [63:0] exp_dout;
        logic [15:0] exp_fc;
        logic [15:0] exp_dc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic v, input logic s, input logic [15:0] d,
                       input logic dv, input logic fd, input logic bz, input logic [63:0] dw,
                       input logic [15:0] fc, input logic [15:0] dc);
        vec_t e;
        e.ce = c; e.valid = v; e.sync = s; e.din = d;
        e.exp_dv = dv; e.exp_fd = fd; e.exp_busy = bz; e.exp_dout = dw;
        e.exp_fc = fc; e.exp_dc = dc;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point
    task automatic step(input logic c, input logic v, input logic s, input logic [15:0] d);
        ce = c; din_valid = v; sync = s; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [63:0] W0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] W1 = 64'h00DD_00CC_00BB_00AA;
    localparam logic [63:0] W2 = 64'h0088_0077_0066_0055;
    localparam logic [63:0] W3 = 64'h0404_0303_0202_0101;

    initial begin
        // basic word, then gapped valids with a 5-cycle ce=0 hold inside a frame
        add(1,1,0,16'h0001, 0,0,1, 64'h0, 0,0);
        add(1,1,0,16'h0002, 0,0,1, 64'h0, 0,0);
        add(1,1,0,16'h0003, 0,0,1, 64'h0, 0,0);
        add(1,1,0,16'h0004, 1,0,0, W0,    1,0);
        add(1,1,0,16'h0001, 0,0,1, W0,    1,0);
        add(1,0,0,16'h0000, 0,0,1, W0,    1,0);
        add(1,0,0,16'h0000, 0,0,1, W0,    1,0);
        add(1,1,0,16'h0002, 0,0,1, W0,    1,0);
        add(0,1,0,16'hFFFF, 0,0,1, W0,    1,0);
        add(0,1,1,16'hEEEE, 0,0,1, W0,    1,0);
        add(0,0,1,16'h0000, 0,0,1, W0,    1,0);
        add(0,1,0,16'hDDDD, 0,0,1, W0,    1,0);
        add(0,0,0,16'h0000, 0,0,1, W0,    1,0);
        add(1,1,0,16'h0003, 0,0,1, W0,    1,0);
        add(1,0,0,16'h0000, 0,0,1, W0,    1,0);
        add(1,0,0,16'h0000, 0,0,1, W0,    1,0);
        add(1,1,0,16'h0004, 1,0,0, W0,    2,0);
        add(1,0,0,16'h0000, 0,0,0, W0,    2,0);
        // two samples then sync carrying 0x00AA
        add(1,1,0,16'h0011, 0,0,1, W0,    2,0);
        add(1,1,0,16'h0022, 0,0,1, W0,    2,0);
        add(1,1,1,16'h00AA, 0,1,1, W0,    2,1);
        add(1,1,0,16'h00BB, 0,0,1, W0,    2,1);
        add(1,1,0,16'h00CC, 0,0,1, W0,    2,1);
        add(1,1,0,16'h00DD, 1,0,0, W1,    3,1);
        // sync without valid drops; repeated sync at lane 0 does not
        add(1,1,0,16'h0001, 0,0,1, W1,    3,1);
        add(1,0,1,16'h0000, 0,1,0, W1,    3,2);
        add(1,0,1,16'h0000, 0,0,0, W1,    3,2);
        // sync on the completing cycle wins
        add(1,1,0,16'h0001, 0,0,1, W1,    3,2);
        add(1,1,0,16'h0002, 0,0,1, W1,    3,2);
        add(1,1,0,16'h0003, 0,0,1, W1,    3,2);
        add(1,1,1,16'h0055, 0,1,1, W1,    3,3);
        add(1,1,0,16'h0066, 0,0,1, W1,    3,3);
        add(1,1,0,16'h0077, 0,0,1, W1,    3,3);
        add(1,1,0,16'h0088, 1,0,0, W2,    4,3);
        // sync with valid at lane 0 starts a frame without a drop
        add(1,1,1,16'h0101, 0,0,1, W2,    4,3);
        add(1,1,0,16'h0202, 0,0,1, W2,    4,3);
        add(1,1,0,16'h0303, 0,0,1, W2,    4,3);
        add(1,1,0,16'h0404, 1,0,0, W3,    5,3);

        do_reset();
        check("reset dout", dout, 64'h0);
        check("reset dout_valid", 64'(dout_valid), 64'h0);
        check("reset frame_drop", 64'(frame_drop), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset frame_count", 64'(frame_count), 64'h0);
        check("reset drop_count", 64'(drop_count), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ce, vecs[i].valid, vecs[i].sync, vecs[i].din);
            check($sformatf("vec%0d dout_valid", i), 64'(dout_valid), 64'(vecs[i].exp_dv));
            check($sformatf("vec%0d frame_drop", i), 64'(frame_drop), 64'(vecs[i].exp_fd));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d frame_count", i), 64'(frame_count), 64'(vecs[i].exp_fc));
            check($sformatf("vec%0d drop_count", i), 64'(drop_count), 64'(vecs[i].exp_dc));
        end

        // 12 back-to-back valids: pulses after the 4th, 8th and 12th sample
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'(i + 1));
            check($sformatf("stream dv%0d", i), 64'(dout_valid), 64'((i % 4) == 3));
        end
        check("stream frame_count", 64'(frame_count), 64'd8);
        check("stream dout", dout, 64'h000C_000B_000A_0009);

        // asynchronous reset mid-frame, no clock edge needed
        step(1'b1, 1'b1, 1'b0, 16'h0A01);
        step(1'b1, 1'b1, 1'b0, 16'h0A02);
        check("pre-reset busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async reset dout", dout, 64'h0);
        check("async reset busy", 64'(busy), 64'h0);
        check("async reset frame_count", 64'(frame_count), 64'h0);
        check("async reset drop_count", 64'(drop_count), 64'h0);
        ce = 1'b0; din_valid = 1'b0; sync = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 16'h0B01);
        step(1'b1, 1'b1, 1'b0, 16'h0B02);
        step(1'b1, 1'b1, 1'b0, 16'h0B03);
        check("post-reset dv early", 64'(dout_valid), 64'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0B04);
        check("post-reset dv", 64'(dout_valid), 64'h1);
        check("post-reset dout", dout, 64'h0B04_0B03_0B02_0B01);
        check("post-reset frame_count", 64'(frame_count), 64'h1);
        check("post-reset drop_count", 64'(drop_count), 64'h0);

        // 2-bit counters: drops saturate at 3, frames wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h1234);
            step(1'b1, 1'b0, 1'b1, 16'h0000);
            check($sformatf("c2 drop_count%0d", i), 64'(drop_count_c2), 64'((i < 3) ? i + 1 : 3));
        end
        check("c16 drop_count", 64'(drop_count), 64'd5);
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 16'(16 * j + k));
            check($sformatf("c2 frame_count%0d", j), 64'(frame_count_c2), 64'((j + 1) % 4));
        end
        check("c2 final frame_count", 64'(frame_count_c2), 64'd1);
        check("c16 frame_count", 64'(frame_count), 64'd5);
        check("c2 dout", dout_c2, 64'h0043_0042_0041_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
